// File: rtl/axis_video_pattern_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream video test-pattern generator.
package axis_video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FRAME_GAP = 2'd1,
    LINE_GAP  = 2'd2,
    SEND      = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  // Smallest bit count b (at least 1) with 2**b >= value.
  function automatic int clogb2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern generator and its sink.
interface axis_video_pattern_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tuser;
  logic                    tready;

  modport master (output tvalid, tdata, tstrb, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pattern_pixel.sv
// Combinational pixel generator: one pixel of the selected pattern at (px, y).
module axis_pattern_pixel
  import axis_video_pattern_gen_pkg::*;
#(
  parameter int PW = 8,
  parameter int XW = 11,
  parameter int H  = 1280
) (
  input  logic [1:0]    mode,
  input  logic [XW-1:0] px,
  input  logic [XW-1:0] y,
  input  logic [7:0]    frame_cnt,
  input  logic [PW-1:0] const_pixel,
  output logic [PW-1:0] pixel
);

  logic [2:0] bar;

  // Bar index uses the full-width column so it spans 0..7 across the line.
  assign bar = 3'(({px, 3'b000}) / (XW+3)'(H));

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_RAMP:  pixel = PW'(px) + PW'(y) + PW'(frame_cnt);
      MODE_BARS:  pixel = {bar, {(PW-3){1'b0}}};
      MODE_CONST: pixel = const_pixel;
      MODE_CHECK: pixel = {PW{px[3] ^ y[3]}};
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern master: frames of lines with programmable
// line/frame blanking, TUSER at start-of-frame and TLAST at end-of-line.
module axis_video_pattern_gen
  import axis_video_pattern_gen_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_PIXEL_WIDTH        = 8,
  parameter int PIXELS_HORIZONTAL    = 1280,
  parameter int PIXELS_VERTICAL      = 1024,
  parameter int C_LINE_GAP           = 3,
  parameter int C_FRAME_GAP          = 1000
) (
  input  logic                     M_AXIS_ACLK,
  input  logic                     M_AXIS_ARESETN,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [C_PIXEL_WIDTH-1:0] const_pixel,
  axis_video_pattern_gen_if.master m_axis,
  output logic [7:0]               frame_cnt,
  output logic                     busy
);

  localparam int DW     = C_M_AXIS_TDATA_WIDTH;
  localparam int PW     = C_PIXEL_WIDTH;
  localparam int PPB    = DW / PW;
  localparam int XW     = clogb2(((PIXELS_HORIZONTAL > PIXELS_VERTICAL) ?
                                  PIXELS_HORIZONTAL : PIXELS_VERTICAL) + 1);
  localparam int MAXGAP = (C_LINE_GAP > C_FRAME_GAP) ? C_LINE_GAP : C_FRAME_GAP;
  localparam int GW     = clogb2(MAXGAP + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(PIXELS_HORIZONTAL - PPB);
  localparam logic [XW-1:0] Y_LAST    = XW'(PIXELS_VERTICAL - 1);
  localparam logic [XW-1:0] X_STEP    = XW'(PPB);
  localparam logic [GW-1:0] LGAP_LAST = GW'((C_LINE_GAP  > 0) ? C_LINE_GAP  - 1 : 0);
  localparam logic [GW-1:0] FGAP_LAST = GW'((C_FRAME_GAP > 0) ? C_FRAME_GAP - 1 : 0);

  state_t        state_reg;
  logic [XW-1:0] x_reg, y_reg;
  logic [GW-1:0] gap_reg;
  logic [1:0]    mode_reg;
  logic [7:0]    frame_reg;
  logic [DW-1:0] tdata_reg;

  logic          beat_ok, line_end, frame_end, relatch;
  logic [XW-1:0] x_next, y_next;
  logic [7:0]    frame_next;
  logic [1:0]    mode_next;
  logic [DW-1:0] pix_next;

  // Position, frame count and mode as they will stand after this edge; the
  // next beat is computed from these so TDATA is ready the cycle it is shown.
  always_comb begin
    beat_ok    = (state_reg == SEND) && m_axis.tready;
    line_end   = (x_reg == X_LAST);
    frame_end  = line_end && (y_reg == Y_LAST);
    x_next     = x_reg;
    y_next     = y_reg;
    frame_next = frame_reg;
    if (beat_ok) begin
      x_next = line_end ? '0 : x_reg + X_STEP;
      if (line_end) y_next = frame_end ? '0 : y_reg + 1'b1;
      if (frame_end) frame_next = frame_reg + 8'd1;
    end
    relatch   = enable && ((state_reg == IDLE) || (beat_ok && frame_end));
    mode_next = relatch ? mode : mode_reg;
  end

  for (genvar gi = 0; gi < PPB; gi++) begin : g_pix
    axis_pattern_pixel #(
      .PW (PW),
      .XW (XW),
      .H  (PIXELS_HORIZONTAL)
    ) u_pix (
      .mode        (mode_next),
      .px          (x_next + XW'(gi)),
      .y           (y_next),
      .frame_cnt   (frame_next),
      .const_pixel (const_pixel),
      .pixel       (pix_next[gi*PW +: PW])
    );
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      gap_reg   <= '0;
      mode_reg  <= MODE_RAMP;
      frame_reg <= '0;
      tdata_reg <= '0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      frame_reg <= frame_next;
      mode_reg  <= mode_next;
      if (!((state_reg == SEND) && !m_axis.tready)) tdata_reg <= pix_next;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            gap_reg   <= '0;
            state_reg <= (C_FRAME_GAP == 0) ? SEND : FRAME_GAP;
          end
        end
        FRAME_GAP: begin
          if (gap_reg == FGAP_LAST) state_reg <= SEND;
          else gap_reg <= gap_reg + 1'b1;
        end
        LINE_GAP: begin
          if (gap_reg == LGAP_LAST) state_reg <= SEND;
          else gap_reg <= gap_reg + 1'b1;
        end
        SEND: begin
          if (beat_ok && line_end) begin
            gap_reg <= '0;
            if (frame_end)
              state_reg <= !enable ? IDLE : ((C_FRAME_GAP == 0) ? SEND : FRAME_GAP);
            else
              state_reg <= (C_LINE_GAP == 0) ? SEND : LINE_GAP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = (state_reg == SEND);
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tstrb  = '1;
  assign m_axis.tlast  = (state_reg == SEND) && line_end;
  assign m_axis.tuser  = (state_reg == SEND) && (x_reg == '0) && (y_reg == '0);
  assign frame_cnt     = frame_reg;
  assign busy          = (state_reg != IDLE);

endmodule
